// File: rtl/uart_mem_controller.sv
// rtl/uart_mem_controller.sv - UART byte-command front end for a private byte RAM
//
// Purpose:
//   Parses byte commands arriving from a UART receiver and services them
//   against an internal byte RAM.
//   Frame layout: [cmd][len][addr_hi][addr_lo][data...]
//   WRITE (CMD_WRITE) stores len+1 bytes from addr onward.
//   READ  (CMD_READ)  returns len+1 bytes through the UART transmitter.
//   Addresses wrap modulo 2**ADDR_WIDTH. Address bits above ADDR_WIDTH are dropped.
//
// Ports:
//   clock            in   system clock, rising edge
//   reset_n          in   asynchronous active-low reset
//   received         in   1-cycle strobe, rx_byte valid
//   rx_byte[7:0]     in   received byte
//   is_transmitting  in   UART transmitter busy
//   transmit         out  1-cycle strobe, send tx_byte
//   tx_byte[7:0]     out  byte to send, held until the next transmit
module uart_mem_controller #(
  parameter int          ADDR_WIDTH = 12,
  parameter logic [7:0]  CMD_WRITE  = 8'h01,
  parameter logic [7:0]  CMD_READ   = 8'h02
) (
  input  logic       clock,
  input  logic       reset_n,
  input  logic       received,
  input  logic [7:0] rx_byte,
  input  logic       is_transmitting,
  output logic       transmit,
  output logic [7:0] tx_byte
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_LEN,
    S_ADDR_HI,
    S_ADDR_LO,
    S_WDATA,
    S_RFETCH,
    S_RSEND,
    S_RWAIT
  } state_t;

  state_t      state_q, state_d;
  logic        is_read_q, is_read_d;
  logic [7:0]  count_q, count_d;
  // Full 16-bit host address is kept; only the low ADDR_WIDTH bits index the RAM,
  // so a 16-bit increment still wraps correctly modulo 2**ADDR_WIDTH.
  logic [15:0] addr_q, addr_d;
  logic [7:0]  tx_byte_q, tx_byte_d;

  logic [7:0]  mem [2**ADDR_WIDTH];
  logic [7:0]  rdata_q;
  logic        mem_we;
  logic        mem_re;
  logic [ADDR_WIDTH-1:0] mem_addr;

  assign mem_addr = addr_q[ADDR_WIDTH-1:0];
  assign mem_we   = (state_q == S_WDATA) && received;
  assign mem_re   = (state_q == S_RFETCH);

  // RAM contents are deliberately not reset.
  always_ff @(posedge clock) begin
    if (mem_we) begin
      mem[mem_addr] <= rx_byte;
    end
    if (mem_re) begin
      rdata_q <= mem[mem_addr];
    end
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q   <= S_IDLE;
      is_read_q <= 1'b0;
      count_q   <= 8'h00;
      addr_q    <= 16'h0000;
      tx_byte_q <= 8'h00;
    end else begin
      state_q   <= state_d;
      is_read_q <= is_read_d;
      count_q   <= count_d;
      addr_q    <= addr_d;
      tx_byte_q <= tx_byte_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    is_read_d = is_read_q;
    count_d   = count_q;
    addr_d    = addr_q;
    tx_byte_d = tx_byte_q;
    transmit  = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (received && (rx_byte == CMD_WRITE || rx_byte == CMD_READ)) begin
          is_read_d = (rx_byte == CMD_READ);
          state_d   = S_LEN;
        end
      end
      S_LEN: begin
        if (received) begin
          count_d = rx_byte;
          state_d = S_ADDR_HI;
        end
      end
      S_ADDR_HI: begin
        if (received) begin
          addr_d[15:8] = rx_byte;
          state_d      = S_ADDR_LO;
        end
      end
      S_ADDR_LO: begin
        if (received) begin
          addr_d[7:0] = rx_byte;
          state_d     = is_read_q ? S_RFETCH : S_WDATA;
        end
      end
      S_WDATA: begin
        if (received) begin
          addr_d = addr_q + 16'd1;
          if (count_q == 8'h00) begin
            state_d = S_IDLE;
          end else begin
            count_d = count_q - 8'd1;
          end
        end
      end
      S_RFETCH: begin
        state_d = S_RSEND;
      end
      S_RSEND: begin
        // transmit is combinational on is_transmitting so it can never
        // coincide with a busy UART, even if busy rises unexpectedly.
        if (!is_transmitting) begin
          transmit  = 1'b1;
          tx_byte_d = rdata_q;
          addr_d    = addr_q + 16'd1;
          state_d   = S_RWAIT;
        end
      end
      S_RWAIT: begin
        if (count_q == 8'h00) begin
          state_d = S_IDLE;
        end else begin
          count_d = count_q - 8'd1;
          state_d = S_RFETCH;
        end
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // Present the fetched byte in the strobe cycle itself, then hold it in tx_byte_q
  // so tx_byte only changes together with a transmit strobe.
  assign tx_byte = transmit ? rdata_q : tx_byte_q;

endmodule

// File: tb/tb_uart_mem_controller.sv
// tb/tb_uart_mem_controller.sv - scoreboard bench for uart_mem_controller
module tb_uart_mem_controller;

  logic       clock = 1'b0;
  logic       reset_n = 1'b0;
  logic       received = 1'b0;
  logic [7:0] rx_byte = 8'h00;
  logic       is_transmitting = 1'b0;
  logic       transmit;
  logic [7:0] tx_byte;

  int n_checks = 0;
  int n_errors = 0;

  logic [7:0] exp_q[$];
  logic [7:0] wbuf[$];
  logic [7:0] model_mem [4096];
  logic       arm_force = 1'b0;

  uart_mem_controller #(
    .ADDR_WIDTH(12),
    .CMD_WRITE(8'h01),
    .CMD_READ(8'h02)
  ) dut (
    .clock(clock),
    .reset_n(reset_n),
    .received(received),
    .rx_byte(rx_byte),
    .is_transmitting(is_transmitting),
    .transmit(transmit),
    .tx_byte(tx_byte)
  );

  always #5 clock = ~clock;

  // UART transmitter model: goes busy the cycle after each transmit strobe.
  always begin
    logic saw;
    int   busy_cnt;
    busy_cnt = 0;
    forever begin
      @(negedge clock);
      saw = transmit;
      @(posedge clock);
      #1;
      if (saw) begin
        busy_cnt = arm_force ? 5 : $urandom_range(0, 3);
      end else if (busy_cnt > 0) begin
        busy_cnt--;
      end
      is_transmitting = (busy_cnt > 0);
    end
  end

  // Monitor: pops the scoreboard on every transmit strobe.
  always begin
    logic       prev_tx;
    logic [7:0] last_tx;
    logic [7:0] exp;
    prev_tx = 1'b0;
    last_tx = 8'h00;
    forever begin
      @(negedge clock);
      if (!reset_n) begin
        last_tx = 8'h00;
      end
      if (transmit) begin
        n_checks++;
        if (is_transmitting) begin
          n_errors++;
          $display("FAIL tx_while_busy: transmit=1 is_transmitting=%0b required 0", is_transmitting);
        end
        n_checks++;
        if (prev_tx) begin
          n_errors++;
          $display("FAIL tx_back_to_back: transmit high two cycles, required single-cycle pulse");
        end
        n_checks++;
        if (exp_q.size() == 0) begin
          n_errors++;
          $display("FAIL unexpected_tx: tx_byte=%02h with no byte expected", tx_byte);
        end else begin
          exp = exp_q.pop_front();
          if (tx_byte !== exp) begin
            n_errors++;
            $display("FAIL tx_data: got %02h required %02h", tx_byte, exp);
          end
        end
        last_tx = tx_byte;
      end else if (reset_n) begin
        n_checks++;
        if (tx_byte !== last_tx) begin
          n_errors++;
          $display("FAIL tx_hold: tx_byte=%02h required %02h", tx_byte, last_tx);
        end
      end
      prev_tx = transmit;
    end
  end

  task automatic send_byte(input logic [7:0] b);
    @(posedge clock);
    #1;
    received = 1'b1;
    rx_byte  = b;
    @(posedge clock);
    #1;
    received = 1'b0;
    repeat ($urandom_range(0, 2)) @(posedge clock);
  endtask

  // Writes the bytes in wbuf; len is wbuf.size()-1.
  task automatic do_write(input logic [15:0] a);
    int n;
    n = wbuf.size();
    send_byte(8'h01);
    send_byte(8'(n - 1));
    send_byte(a[15:8]);
    send_byte(a[7:0]);
    for (int i = 0; i < n; i++) begin
      model_mem[(int'(a) + i) % 4096] = wbuf[i];
      send_byte(wbuf[i]);
    end
  endtask

  task automatic wait_drain(input int keep, input bit inject);
    int cyc;
    cyc = 0;
    while (exp_q.size() > keep && cyc < 2000) begin
      @(posedge clock);
      #1;
      received = inject && (exp_q.size() > 0) && ($urandom_range(0, 3) == 0);
      rx_byte  = 8'h01;
      cyc++;
    end
    received = 1'b0;
    if (cyc >= 2000) begin
      n_checks++;
      n_errors++;
      $display("FAIL read_timeout: %0d bytes still expected, required %0d", exp_q.size(), keep);
      exp_q.delete();
    end
  endtask

  task automatic start_read(input logic [15:0] a, input logic [7:0] len);
    for (int i = 0; i <= int'(len); i++) begin
      exp_q.push_back(model_mem[(int'(a) + i) % 4096]);
    end
    send_byte(8'h02);
    send_byte(len);
    send_byte(a[15:8]);
    send_byte(a[7:0]);
  endtask

  task automatic do_read(input logic [15:0] a, input logic [7:0] len, input bit inject);
    start_read(a, len);
    wait_drain(0, inject);
    repeat (3) @(posedge clock);
  endtask

  initial begin
    logic [15:0] a;
    int          n;
    int          off;
    int          rl;

    repeat (3) @(posedge clock);
    #1;
    n_checks++;
    if (transmit !== 1'b0) begin
      n_errors++;
      $display("FAIL reset_transmit: got %0b required 0", transmit);
    end
    n_checks++;
    if (tx_byte !== 8'h00) begin
      n_errors++;
      $display("FAIL reset_tx_byte: got %02h required 00", tx_byte);
    end
    reset_n = 1'b1;
    repeat (2) @(posedge clock);

    // 1: basic write then read
    wbuf = '{8'h42, 8'h43, 8'h44};
    do_write(16'h0ECD);
    do_read(16'h0ECD, 8'd2, 1'b0);

    // 2: read with a long busy period after each byte
    wbuf = '{8'h44, 8'h45, 8'h46};
    do_write(16'h0A10);
    arm_force = 1'b1;
    do_read(16'h0A10, 8'd2, 1'b0);
    arm_force = 1'b0;

    // 3: single-byte transfer
    wbuf = '{8'h99};
    do_write(16'h0005);
    do_read(16'h0005, 8'd0, 1'b0);

    // 4: unknown command byte is ignored
    send_byte(8'h7F);
    wbuf = '{8'h5A, 8'hA5};
    do_write(16'h0200);
    do_read(16'h0200, 8'd1, 1'b0);

    // 5: address wrap from 0xFFF to 0x000
    wbuf = '{8'hAA, 8'hBB};
    do_write(16'h0FFF);
    do_read(16'h0000, 8'd0, 1'b0);
    do_read(16'h0FFF, 8'd1, 1'b0);

    // 6: reset during a read after the first byte went out
    start_read(16'h0ECD, 8'd2);
    wait_drain(2, 1'b0);
    @(posedge clock);
    #1;
    reset_n = 1'b0;
    #1;
    n_checks++;
    if (transmit !== 1'b0) begin
      n_errors++;
      $display("FAIL abort_transmit: got %0b required 0", transmit);
    end
    n_checks++;
    if (tx_byte !== 8'h00) begin
      n_errors++;
      $display("FAIL abort_tx_byte: got %02h required 00", tx_byte);
    end
    exp_q.delete();
    repeat (3) @(posedge clock);
    #1;
    reset_n = 1'b1;
    repeat (20) @(posedge clock);
    wbuf = '{8'h11, 8'h22, 8'h33, 8'h44};
    do_write(16'h0300);
    do_read(16'h0300, 8'd3, 1'b0);

    // Randomized writes and sub-range reads, with dropped strobes mid-read
    for (int it = 0; it < 25; it++) begin
      a = 16'($urandom_range(0, 65535));
      if ($urandom_range(0, 3) == 0) begin
        a[11:0] = 12'hFF0 + 12'($urandom_range(0, 15));
      end
      n = $urandom_range(1, 16);
      wbuf.delete();
      for (int i = 0; i < n; i++) begin
        wbuf.push_back(8'($urandom));
      end
      do_write(a);
      off = $urandom_range(0, n - 1);
      rl  = $urandom_range(0, n - 1 - off);
      a[11:0] = a[11:0] + 12'(off);
      a[15:12] = 4'($urandom);
      do_read(a, 8'(rl), 1'b1);
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
